// File: rtl/fuzzifier.sv
// Crisp-to-fuzzy front end: signed T/D samples become six Q1.15 neg/zero/pos degrees.
// One serial restoring divider is shared by both axes. Optional: FUZZIFIER_DEADBAND_EN.
module fuzzifier #(
    parameter int unsigned W_T  = 1280,
    parameter int unsigned W_D  = 256,
    parameter int unsigned DB_T = 0,
    parameter int unsigned DB_D = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] T_in,
    input  logic signed [15:0] D_in,
    output logic [15:0]        muT_neg,
    output logic [15:0]        muT_zero,
    output logic [15:0]        muT_pos,
    output logic [15:0]        muD_neg,
    output logic [15:0]        muD_zero,
    output logic [15:0]        muD_pos,
    output logic               out_valid
);

    if (W_T == 0 || W_T > 32767) begin : g_bad_wt
        $error("W_T must be in 1..32767");
    end
    if (W_D == 0 || W_D > 32767) begin : g_bad_wd
        $error("W_D must be in 1..32767");
    end
    if (DB_T > 32767 || DB_D > 32767) begin : g_bad_db
        $error("DB_T/DB_D must be in 0..32767");
    end

    localparam logic [15:0] WT   = 16'(W_T);
    localparam logic [15:0] WD   = 16'(W_D);
    localparam logic [15:0] ONE  = 16'd32767;

    typedef enum logic [1:0] {StIdle, StDivT, StDivD, StDone} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q;
    logic [15:0] rem_q;
    logic [14:0] quo_q;
    logic [15:0] qt_q;
    logic [15:0] at_q, ad_q;
    logic        negt_q, negd_q;

    logic        accept;
    logic [16:0] mt, md;
    logic [15:0] at_c, ad_c;
    logic [15:0] w_cur, rem_sub, rem_nx;
    logic        ge;
    logic [15:0] quo_nx, ft, fd;

    function automatic logic [16:0] mag(input logic signed [15:0] x);
        logic [16:0] s;
        s = {x[15], x};
        return x[15] ? (17'd0 - s) : s;
    endfunction

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign accept    = in_valid && in_ready;

    // Magnitudes are clamped at accept so the divider only ever sees a <= W.
    always_comb begin
        mt = mag(T_in);
        md = mag(D_in);
`ifdef FUZZIFIER_DEADBAND_EN
        mt = (mt <= 17'(DB_T)) ? 17'd0 : mt - 17'(DB_T);
        md = (md <= 17'(DB_D)) ? 17'd0 : md - 17'(DB_D);
`endif
        at_c = (mt > {1'b0, WT}) ? WT : mt[15:0];
        ad_c = (md > {1'b0, WD}) ? WD : md[15:0];
    end

    always_comb begin
        w_cur   = (state_q == StDivD) ? WD : WT;
        ge      = (rem_q >= w_cur);
        rem_sub = ge ? rem_q - w_cur : rem_q;
        rem_nx  = rem_sub << 1;
        quo_nx  = {quo_q, ge};
        // q can reach exactly 32768 when a == W; saturate to 1.0 in Q1.15.
        ft      = qt_q[15] ? ONE : qt_q;
        fd      = quo_nx[15] ? ONE : quo_nx;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StDivT;
            StDivT:  if (cnt_q == 5'd16) state_d = StDivD;
            StDivD:  if (cnt_q == 5'd15) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            qt_q     <= '0;
            at_q     <= '0;
            ad_q     <= '0;
            negt_q   <= 1'b0;
            negd_q   <= 1'b0;
            muT_neg  <= '0;
            muT_zero <= '0;
            muT_pos  <= '0;
            muD_neg  <= '0;
            muD_zero <= '0;
            muD_pos  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        at_q   <= at_c;
                        ad_q   <= ad_c;
                        negt_q <= T_in[15];
                        negd_q <= D_in[15];
                        cnt_q  <= '0;
                    end
                end
                StDivT: begin
                    // First DIV_T cycle primes the remainder; the next 16 produce quotient bits.
                    if (cnt_q == 5'd0) begin
                        rem_q <= at_q;
                        quo_q <= '0;
                        cnt_q <= cnt_q + 5'd1;
                    end else if (cnt_q == 5'd16) begin
                        qt_q  <= quo_nx;
                        rem_q <= ad_q;
                        quo_q <= '0;
                        cnt_q <= '0;
                    end else begin
                        rem_q <= rem_nx;
                        quo_q <= quo_nx[14:0];
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                StDivD: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx[14:0];
                    if (cnt_q == 5'd15) begin
                        cnt_q    <= '0;
                        muT_neg  <= negt_q ? ft : 16'd0;
                        muT_pos  <= negt_q ? 16'd0 : ft;
                        muT_zero <= ONE - ft;
                        muD_neg  <= negd_q ? fd : 16'd0;
                        muD_pos  <= negd_q ? 16'd0 : fd;
                        muD_zero <= ONE - fd;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                StDone: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fuzzifier.sv
// Randomised scoreboard bench for fuzzifier: driver pushes model results at accept,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_fuzzifier;

    localparam int WT  = 1280;
    localparam int WD  = 256;
    localparam int DBT = 128;
    localparam int DBD = 0;
`ifdef FUZZIFIER_DEADBAND_EN
    localparam bit DbEn = 1'b1;
`else
    localparam bit DbEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic signed [15:0] T_in = '0;
    logic signed [15:0] D_in = '0;
    logic [15:0] muT_neg, muT_zero, muT_pos, muD_neg, muD_zero, muD_pos;
    logic out_valid;

    fuzzifier #(.W_T(WT), .W_D(WD), .DB_T(DBT), .DB_D(DBD)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .T_in(T_in), .D_in(D_in),
        .muT_neg(muT_neg), .muT_zero(muT_zero), .muT_pos(muT_pos),
        .muD_neg(muD_neg), .muD_zero(muD_zero), .muD_pos(muD_pos),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int tn, tz, tp, dn, dz, dp;
        int acc;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Degree of membership in the outer set: linear ramp from 0 at x=0 to 1.0 at |x|=W.
    function automatic int ramp(input int x, input int w, input int db);
        int a, q;
        a = (x < 0) ? -x : x;
        if (DbEn) a = (a <= db) ? 0 : a - db;
        if (a > w) a = w;
        q = (a * 32768) / w;
        return (q > 32767) ? 32767 : q;
    endfunction

    function automatic exp_t model(input int t, input int d, input int acc);
        exp_t e;
        int ft, fd;
        ft = ramp(t, WT, DBT);
        fd = ramp(d, WD, DBD);
        e.tn = 0; e.tp = 0; e.dn = 0; e.dp = 0;
        if (t > 0) e.tp = ft;
        else if (t < 0) e.tn = ft;
        if (d > 0) e.dp = fd;
        else if (d < 0) e.dn = fd;
        e.tz = 32767 - e.tn - e.tp;
        e.dz = 32767 - e.dn - e.dp;
        e.acc = acc;
        return e;
    endfunction

    // Monitor
    logic prev_ov = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov <= 1'b0;
        end else begin
            if (prev_ov) chk("out_valid_width", int'(out_valid), 0);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("latency", cyc - e.acc, 33);
                    chk("muT_neg", int'(muT_neg), e.tn);
                    chk("muT_zero", int'(muT_zero), e.tz);
                    chk("muT_pos", int'(muT_pos), e.tp);
                    chk("muD_neg", int'(muD_neg), e.dn);
                    chk("muD_zero", int'(muD_zero), e.dz);
                    chk("muD_pos", int'(muD_pos), e.dp);
                    chk("sumT", int'(muT_neg) + int'(muT_zero) + int'(muT_pos), 32767);
                    chk("sumD", int'(muD_neg) + int'(muD_zero) + int'(muD_pos), 32767);
                end
            end
            prev_ov <= out_valid;
        end
    end

    // Called just after a negedge; returns once the sample has been taken.
    task automatic send(input logic signed [15:0] t, input logic signed [15:0] d);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        T_in = t;
        D_in = d;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
        end else begin
            exp_q.push_back(model(int'(t), int'(d), cyc + 1));
        end
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        T_in = 16'($urandom);
        D_in = 16'($urandom);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (!(exp_q.size() == 0 && in_ready) && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    function automatic logic signed [15:0] rnd_val(input int w);
        int m;
        m = int'($urandom_range(0, 3));
        if (m == 0) return 16'($urandom);
        if (m == 1) return 16'(int'($urandom_range(0, 2 * w)) - w);
        if (m == 2) return ($urandom_range(0, 1) == 1) ? 16'(w) : 16'(-w);
        return 16'(int'($urandom_range(0, 8)) - 4);
    endfunction

    initial begin
        int last;
        int guard;

        // Reset
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_muT_neg", int'(muT_neg), 0);
        chk("rst_muT_zero", int'(muT_zero), 0);
        chk("rst_muD_zero", int'(muD_zero), 0);
        chk("rst_muD_pos", int'(muD_pos), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;

        // Mid-ramp
        send(16'sd640, -16'sd128);
        drain();
        chk("mid_muT_pos", int'(muT_pos), 16384);
        chk("mid_muD_neg", int'(muD_neg), 16384);
        chk("mid_muD_zero", int'(muD_zero), 16383);

        // Origin
        send(16'sd0, 16'sd0);
        drain();
        chk("org_muT_zero", int'(muT_zero), 32767);
        chk("org_muD_zero", int'(muD_zero), 32767);

        // Saturation
        send(-16'sd32768, 16'sd32767);
        drain();
        chk("sat_muT_neg", int'(muT_neg), 32767);
        chk("sat_muD_pos", int'(muD_pos), 32767);

        // Deadband points (plain ramp when the feature is off)
        send(16'sd100, 16'sd1);
        drain();
        chk("db_small_muT_zero", int'(muT_zero), DbEn ? 32767 : 30207);
        send(16'sd768, -16'sd1);
        drain();
        chk("db_big_muT_pos", int'(muT_pos), DbEn ? 16384 : 19660);

        // Random traffic
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            #1;
            send(rnd_val(WT), rnd_val(WD));
        end
        drain();

        // in_valid held high; inputs change 5 cycles into each operation
        in_valid = 1'b1;
        T_in = rnd_val(WT);
        D_in = rnd_val(WD);
        last = 0;
        for (int j = 0; j < 4; j++) begin
            guard = 0;
            while (!in_ready && guard < 60) begin
                @(negedge clk);
                #1;
                guard++;
                if (guard == 5) begin
                    T_in = rnd_val(WT);
                    D_in = rnd_val(WD);
                end
            end
            if (!in_ready) chk("held_timeout", 0, 1);
            if (j > 0) chk("ready_return", cyc, last + 34);
            exp_q.push_back(model(int'(T_in), int'(D_in), cyc + 1));
            last = cyc + 1;
            @(negedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();

        // Abort by reset at cycle 10 of an operation
        send(16'sd900, -16'sd200);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("abort_muT_pos", int'(muT_pos), 0);
        chk("abort_muT_zero", int'(muT_zero), 0);
        chk("abort_muD_neg", int'(muD_neg), 0);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        chk("post_abort_muT_zero", int'(muT_zero), 0);

        // One more sample after the abort to show the block recovered
        send(-16'sd640, 16'sd256);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
